dualshock_responder: RTL and testbench
======================================

DUALSHOCK_RESPONDER -- requirements
Module: dualshock_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 100, meaning I_CLK cycles from the 8th sampled psCLK rising edge to O_psACK assertion (1..255).
REQ-002 SHALL have parameter ACK_WIDTH, default 50, meaning I_CLK cycles O_psACK is held low (1..255).
REQ-003 SHALL have port I_CLK  input  1  system clock, at least 8x the psCLK rate (25.2 MHz nominal).
REQ-004 SHALL have port I_RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I_psCLK  input  1  host serial clock, idles high, asynchronous to I_CLK.
REQ-006 SHALL have port I_psSEL  input  1  host attention/select, active-low, asynchronous.
REQ-007 SHALL have port I_psTXD  input  1  host command data, LSB first, asynchronous.
REQ-008 SHALL have port O_psRXD  output  1  response data to host, LSB first, idle high.
REQ-009 SHALL have port O_psACK  output  1  acknowledge, active-low pulse.
REQ-010 SHALL have port I_MODE  input  1  0 = digital (ID 0x41), 1 = analog (ID 0x73).
REQ-011 SHALL have ports I_BTN1, I_BTN2  input  8 each  button bytes, active-low (0 = pressed).
REQ-012 SHALL have ports I_RX, I_RY, I_LX, I_LY  input  8 each  stick axes, 0x80 = centre.
REQ-013 SHALL have ports O_VIB0, O_VIB1  output  8 each  host bytes 3 and 4 from the last completed poll.
REQ-014 SHALL have port O_POLLED  output  1  one-cycle pulse when a poll completes.

Function
REQ-015 SHALL pass I_psCLK, I_psSEL, I_psTXD through 2-flop synchronisers; all edge detection uses synchronised values.
REQ-016 SHALL use states IDLE, SHIFT, ACK_WAIT, ACK, IGNORE.
REQ-017 IDLE -> SHIFT on synchronised psSEL falling edge; byte index = 0, bit count = 0; entire response snapshotted: {0xFF, ID, 0x5A, BTN1, BTN2, RX, RY, LX, LY}.
REQ-018 In SHIFT, on each psCLK falling edge: drive O_psRXD = next response bit of current byte, LSB first.
REQ-019 In SHIFT, on each psCLK rising edge: shift psTXD into receive register (LSB first); increment bit count.
REQ-020 After the 8th rising edge, the byte is complete; decode as follows.
REQ-021 Byte 0: received value != 0x01 -> IGNORE.
REQ-022 Byte 1: received value != 0x42 -> IGNORE.
REQ-023 Bytes 3 and 4: received values held in a staging register (not yet on O_VIB*).
REQ-024 Last byte = index 4 (I_MODE=0) or index 8 (I_MODE=1, mode sampled at SEL fall).
REQ-025 On the last byte: copy staging to O_VIB0/O_VIB1; pulse O_POLLED; -> IGNORE; no ACK.
REQ-026 On any other completed byte: -> ACK_WAIT.
REQ-027 ACK_WAIT counts ACK_DELAY cycles -> ACK.
REQ-028 ACK drives O_psACK = 0 for ACK_WIDTH cycles -> SHIFT with byte index + 1 and bit count = 0.
REQ-029 psCLK edges arriving in ACK_WAIT/ACK SHALL be ignored.
REQ-030 IGNORE holds O_psRXD = 1 and O_psACK = 1 until SEL high.
REQ-031 Synchronised psSEL high in any state -> IDLE within 1 cycle: O_psRXD = 1, O_psACK = 1, counters cleared, O_VIB* unchanged (abort mid-byte or mid-ACK included).
REQ-032 A new SEL falling edge is recognised only from IDLE.
REQ-033 Input-edge-to-output latency SHALL be at most 3 I_CLK cycles.

Reset
REQ-034 While I_RSTn = 0: state = IDLE; O_psRXD = 1; O_psACK = 1; O_POLLED = 0; O_VIB0 = O_VIB1 = 0x00; synchronisers = idle-high values; counters = 0.
REQ-035 Leaving reset with psSEL already low SHALL NOT start a transaction until a fresh SEL falling edge.

Verification
REQ-036 Digital poll: I_MODE=0, BTN1=0xFE, BTN2=0xBF; host sends 01 42 00 AA 55 -> receives FF 41 5A FE BF; 4 ACK pulses of ACK_WIDTH cycles; O_VIB0=0xAA, O_VIB1=0x55; one O_POLLED pulse.
REQ-037 Analog poll: I_MODE=1, axes 0x80/0x7F/0x00/0xFF -> 9 bytes FF 73 5A BTN1 BTN2 80 7F 00 FF; 8 ACKs; none after byte 8.
REQ-038 Wrong address: host byte 0 = 0x81 -> no ACK; O_psRXD high until SEL rises; O_VIB* unchanged; no O_POLLED.
REQ-039 Abort: SEL raised after 3 bits of byte 3 -> IDLE within 3 cycles; O_VIB* unchanged; next full poll succeeds normally.
REQ-040 ACK timing: ACK_DELAY=10, ACK_WIDTH=4 -> O_psACK low exactly 4 cycles, starting 10 cycles (+ sync latency) after 8th psCLK rise.
REQ-041 Reset mid-ACK: I_RSTn low during O_psACK=0 -> O_psACK=1 immediately (asynchronous), all outputs at reset values.

Source files
------------

// File: rtl/dualshock_responder.sv
// DualShock-style pad responder: answers host polls on the PlayStation serial bus
// with digital or analog pad data and captures the host's vibration bytes.
module dualshock_responder #(
    parameter int unsigned ACK_DELAY = 100,
    parameter int unsigned ACK_WIDTH = 50
) (
    input  logic       I_CLK,
    input  logic       I_RSTn,
    input  logic       I_psCLK,
    input  logic       I_psSEL,
    input  logic       I_psTXD,
    output logic       O_psRXD,
    output logic       O_psACK,
    input  logic       I_MODE,
    input  logic [7:0] I_BTN1,
    input  logic [7:0] I_BTN2,
    input  logic [7:0] I_RX,
    input  logic [7:0] I_RY,
    input  logic [7:0] I_LX,
    input  logic [7:0] I_LY,
    output logic [7:0] O_VIB0,
    output logic [7:0] O_VIB1,
    output logic       O_POLLED
);

    typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK, IGNORE} state_t;

    localparam logic [7:0] DELAY_LAST = 8'(ACK_DELAY - 1);
    localparam logic [7:0] WIDTH_LAST = 8'(ACK_WIDTH - 1);

    state_t      state_q, state_d;

    logic [1:0]  clk_sync, sel_sync, txd_sync;
    logic        clk_s, sel_s, txd_s;
    logic        clk_d, sel_d;
    logic        clk_rise, clk_fall, sel_fall;
    logic [1:0]  flush_cnt;
    logic        sel_armed;

    logic [7:0]  resp [9];
    logic        mode_q;
    logic [3:0]  byte_idx;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  wait_cnt;
    logic [7:0]  stage0, stage1;
    logic        byte_done, last_byte, poll_done;

    assign clk_s = clk_sync[1];
    assign sel_s = sel_sync[1];
    assign txd_s = txd_sync[1];

    assign clk_rise = clk_s & ~clk_d;
    assign clk_fall = ~clk_s & clk_d;
    // Armed only after SEL has been seen high once the synchronisers hold real
    // pin values, so a SEL already low when reset ends cannot start a poll.
    assign sel_fall = sel_armed & sel_d & ~sel_s;

    assign rx_byte   = {txd_s, rx_sr[7:1]};
    assign tx_byte   = resp[byte_idx];
    assign byte_done = (state_q == SHIFT) && clk_rise && (bit_cnt == 3'd7);
    assign last_byte = (byte_idx == (mode_q ? 4'd8 : 4'd4));
    assign poll_done = byte_done && last_byte && !sel_s;

    always_comb begin
        state_d = state_q;
        if (sel_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_fall)
                        state_d = SHIFT;
                end
                SHIFT: begin
                    if (byte_done) begin
                        if (byte_idx == 4'd0 && rx_byte != 8'h01)
                            state_d = IGNORE;
                        else if (byte_idx == 4'd1 && rx_byte != 8'h42)
                            state_d = IGNORE;
                        else if (last_byte)
                            state_d = IGNORE;
                        else
                            state_d = ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (wait_cnt == DELAY_LAST)
                        state_d = ACK;
                end
                ACK: begin
                    if (wait_cnt == WIDTH_LAST)
                        state_d = SHIFT;
                end
                IGNORE: state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            clk_sync  <= '1;
            sel_sync  <= '1;
            txd_sync  <= '1;
            clk_d     <= 1'b1;
            sel_d     <= 1'b1;
            flush_cnt <= '0;
            sel_armed <= 1'b0;
            for (int unsigned i = 0; i < 9; i++)
                resp[i] <= '0;
            mode_q    <= 1'b0;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            wait_cnt  <= '0;
            stage0    <= '0;
            stage1    <= '0;
            O_psRXD   <= 1'b1;
            O_psACK   <= 1'b1;
            O_POLLED  <= 1'b0;
            O_VIB0    <= '0;
            O_VIB1    <= '0;
        end else begin
            clk_sync <= {clk_sync[0], I_psCLK};
            sel_sync <= {sel_sync[0], I_psSEL};
            txd_sync <= {txd_sync[0], I_psTXD};
            clk_d    <= clk_s;
            sel_d    <= sel_s;

            if (flush_cnt != 2'd3)
                flush_cnt <= flush_cnt + 2'd1;
            else if (sel_s && sel_d)
                sel_armed <= 1'b1;

            O_POLLED <= poll_done;
            O_psACK  <= (state_d != ACK);

            case (state_q)
                IDLE: begin
                    if (state_d == SHIFT) begin
                        mode_q  <= I_MODE;
                        resp[0] <= 8'hFF;
                        resp[1] <= I_MODE ? 8'h73 : 8'h41;
                        resp[2] <= 8'h5A;
                        resp[3] <= I_BTN1;
                        resp[4] <= I_BTN2;
                        resp[5] <= I_RX;
                        resp[6] <= I_RY;
                        resp[7] <= I_LX;
                        resp[8] <= I_LY;
                    end
                end
                SHIFT: begin
                    if (clk_fall)
                        O_psRXD <= tx_byte[bit_cnt];
                    if (clk_rise) begin
                        rx_sr   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        wait_cnt <= '0;
                        if (byte_idx == 4'd3)
                            stage0 <= rx_byte;
                        if (byte_idx == 4'd4)
                            stage1 <= rx_byte;
                    end
                    // In digital mode byte 4 is the last one, so its value bypasses staging.
                    if (poll_done) begin
                        O_VIB0 <= stage0;
                        O_VIB1 <= (byte_idx == 4'd4) ? rx_byte : stage1;
                    end
                end
                ACK_WAIT: begin
                    wait_cnt <= (state_d == ACK) ? '0 : wait_cnt + 8'd1;
                end
                ACK: begin
                    if (state_d == SHIFT) begin
                        wait_cnt <= '0;
                        bit_cnt  <= '0;
                        byte_idx <= byte_idx + 4'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase

            if (state_d == IDLE || state_d == IGNORE)
                O_psRXD <= 1'b1;
            if (state_d == IDLE) begin
                byte_idx <= '0;
                bit_cnt  <= '0;
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dualshock_responder.sv
// Randomised scoreboard bench for dualshock_responder: a host model drives polls,
// monitors compare returned bytes, ACK pulses and vibration captures against a reference.
module tb_dualshock_responder;

    localparam int unsigned ACK_DELAY = 10;
    localparam int unsigned ACK_WIDTH = 4;
    localparam int HALF = 6;
    localparam int ACK_BUDGET = ACK_DELAY + ACK_WIDTH + 20;

    logic       I_CLK = 1'b0;
    logic       I_RSTn, I_psCLK, I_psSEL, I_psTXD, I_MODE;
    logic       O_psRXD, O_psACK, O_POLLED;
    logic [7:0] I_BTN1, I_BTN2, I_RX, I_RY, I_LX, I_LY;
    logic [7:0] O_VIB0, O_VIB1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int ack_total = 0;
    int polled_total = 0;
    time t_rise = 0;
    time t_fall = 0;

    logic [7:0]  exp_rx_q[$];
    logic [15:0] exp_vib_q[$];
    logic [7:0]  host [9];
    logic [7:0]  mdl_vib0 = 8'h00;
    logic [7:0]  mdl_vib1 = 8'h00;

    dualshock_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
        .I_CLK(I_CLK), .I_RSTn(I_RSTn),
        .I_psCLK(I_psCLK), .I_psSEL(I_psSEL), .I_psTXD(I_psTXD),
        .O_psRXD(O_psRXD), .O_psACK(O_psACK), .I_MODE(I_MODE),
        .I_BTN1(I_BTN1), .I_BTN2(I_BTN2),
        .I_RX(I_RX), .I_RY(I_RY), .I_LX(I_LX), .I_LY(I_LY),
        .O_VIB0(O_VIB0), .O_VIB1(O_VIB1), .O_POLLED(O_POLLED)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Byte monitor: assembles what the host sees on psRXD at each psCLK rise.
    logic [7:0] mbyte = 8'h00;
    int mbit = 0;
    always @(posedge I_psCLK or posedge I_psSEL) begin
        if (I_psSEL === 1'b1) begin
            mbit = 0;
        end else begin
            t_rise = $time;
            if (mon_en) begin
                mbyte = {O_psRXD, mbyte[7:1]};
                mbit++;
                if (mbit == 8) begin
                    mbit = 0;
                    if (exp_rx_q.size() == 0)
                        chk("rx_unexpected", 1, 0);
                    else
                        chk("rx_byte", int'(mbyte), int'(exp_rx_q.pop_front()));
                end
            end
        end
    end

    // ACK monitor: delay from the 8th psCLK rise, and pulse width.
    always @(O_psACK) begin
        if (mon_en) begin
            if (O_psACK === 1'b0) begin
                t_fall = $time;
                chk_range("ack_delay", int'((t_fall - t_rise) / 10), ACK_DELAY, ACK_DELAY + 4);
            end else if (O_psACK === 1'b1) begin
                chk("ack_width", int'(($time - t_fall) / 10), ACK_WIDTH);
                ack_total++;
            end
        end
    end

    logic prev_polled = 1'b0;
    logic [15:0] vib_exp;
    always @(negedge I_CLK) begin
        if (O_POLLED === 1'b1) begin
            polled_total++;
            if (prev_polled)
                chk("polled_width", 2, 1);
            if (exp_vib_q.size() == 0) begin
                chk("poll_unexpected", 1, 0);
            end else begin
                vib_exp = exp_vib_q.pop_front();
                chk("vib0", int'(O_VIB0), int'(vib_exp[15:8]));
                chk("vib1", int'(O_VIB1), int'(vib_exp[7:0]));
            end
        end
        prev_polled = O_POLLED;
    end

    task automatic step(input int n);
        repeat (n) @(posedge I_CLK);
        #1;
    endtask

    task automatic shift_bits(input logic [7:0] b, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            I_psCLK = 1'b0;
            I_psTXD = b[k];
            step(HALF);
            I_psCLK = 1'b1;
            step(HALF);
        end
    endtask

    task automatic wait_ack(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < ACK_BUDGET && !seen; c++) begin
            step(1);
            if (O_psACK === 1'b0)
                seen = 1'b1;
        end
        if (seen)
            for (int c = 0; c < ACK_WIDTH + 4 && O_psACK === 1'b0; c++)
                step(1);
    endtask

    // Host transaction plus reference model of the protocol outcome.
    task automatic run_txn(input bit mode, input bit abort);
        logic [7:0] resp [9];
        bit full, seen;
        int n, acks0, polls0;
        full = (host[0] == 8'h01) && (host[1] == 8'h42);
        if (host[0] != 8'h01)      n = 1;
        else if (host[1] != 8'h42) n = 2;
        else                       n = mode ? 9 : 5;
        resp = '{8'hFF, (mode ? 8'h73 : 8'h41), 8'h5A, I_BTN1, I_BTN2, I_RX, I_RY, I_LX, I_LY};
        I_MODE = mode;
        acks0  = ack_total;
        polls0 = polled_total;
        for (int i = 0; i < n; i++)
            if (!(abort && i >= 3))
                exp_rx_q.push_back(resp[i]);
        if (full && !abort)
            exp_vib_q.push_back({host[3], host[4]});

        I_psSEL = 1'b0;
        step(4);
        I_MODE = 1'($urandom);
        I_BTN1 = 8'($urandom); I_BTN2 = 8'($urandom);
        I_RX = 8'($urandom); I_RY = 8'($urandom);
        I_LX = 8'($urandom); I_LY = 8'($urandom);

        for (int i = 0; i < n; i++) begin
            if (abort && i == 3) begin
                shift_bits(host[i], 3);
                break;
            end
            shift_bits(host[i], 8);
            wait_ack(seen);
            if (i < n - 1) begin
                chk("ack_seen", int'(seen), 1);
            end else begin
                chk("no_ack_last", int'(seen), 0);
                chk("rxd_high_ignore", int'(O_psRXD), 1);
            end
        end

        I_psSEL = 1'b1;
        if (abort) begin
            step(3);
            chk("abort_rxd", int'(O_psRXD), 1);
        end
        step(6);
        if (full && !abort) begin
            mdl_vib0 = host[3];
            mdl_vib1 = host[4];
        end
        chk("ack_count", ack_total - acks0, abort ? 3 : n - 1);
        chk("poll_count", polled_total - polls0, (full && !abort) ? 1 : 0);
        chk("vib0_hold", int'(O_VIB0), int'(mdl_vib0));
        chk("vib1_hold", int'(O_VIB1), int'(mdl_vib1));
        chk("rx_q_empty", exp_rx_q.size(), 0);
        chk("vib_q_empty", exp_vib_q.size(), 0);
    endtask

    task automatic reset_mid_ack();
        bit seen;
        mon_en  = 1'b0;
        I_psSEL = 1'b0;
        step(4);
        shift_bits(8'h01, 8);
        seen = 1'b0;
        for (int c = 0; c < ACK_BUDGET && !seen; c++) begin
            step(1);
            if (O_psACK === 1'b0)
                seen = 1'b1;
        end
        chk("rst_ack_reached", int'(seen), 1);
        I_RSTn = 1'b0;
        #1;
        chk("rst_ack", int'(O_psACK), 1);
        chk("rst_rxd", int'(O_psRXD), 1);
        chk("rst_polled", int'(O_POLLED), 0);
        chk("rst_vib0", int'(O_VIB0), 0);
        chk("rst_vib1", int'(O_VIB1), 0);
        mdl_vib0 = 8'h00;
        mdl_vib1 = 8'h00;
        step(3);
        I_RSTn = 1'b1;
        step(5);
        shift_bits(8'h01, 8);
        wait_ack(seen);
        chk("no_start_after_reset", int'(seen), 0);
        I_psSEL = 1'b1;
        step(6);
        mon_en = 1'b1;
    endtask

    initial begin
        bit m, ab;
        I_RSTn = 1'b0;
        I_psCLK = 1'b1; I_psSEL = 1'b1; I_psTXD = 1'b1; I_MODE = 1'b0;
        I_BTN1 = 8'hFF; I_BTN2 = 8'hFF;
        I_RX = 8'h80; I_RY = 8'h80; I_LX = 8'h80; I_LY = 8'h80;
        step(3);
        chk("reset_rxd", int'(O_psRXD), 1);
        chk("reset_ack", int'(O_psACK), 1);
        chk("reset_polled", int'(O_POLLED), 0);
        chk("reset_vib0", int'(O_VIB0), 0);
        chk("reset_vib1", int'(O_VIB1), 0);
        I_RSTn = 1'b1;
        step(5);
        mon_en = 1'b1;

        I_BTN1 = 8'hFE; I_BTN2 = 8'hBF;
        host = '{8'h01, 8'h42, 8'h00, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b0, 1'b0);

        I_BTN1 = 8'hF7; I_BTN2 = 8'h7F;
        I_RX = 8'h80; I_RY = 8'h7F; I_LX = 8'h00; I_LY = 8'hFF;
        host = '{8'h01, 8'h42, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b1, 1'b0);

        host[0] = 8'h81;
        run_txn(1'b0, 1'b0);

        host = '{8'h01, 8'h42, 8'h00, 8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
        I_BTN1 = 8'h00;
        run_txn(1'b1, 1'b1);
        host = '{8'h01, 8'h42, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b0, 1'b0);

        reset_mid_ack();
        host = '{8'h01, 8'h42, 8'h00, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b1, 1'b0);

        repeat (20) begin
            m = 1'($urandom);
            I_BTN1 = 8'($urandom); I_BTN2 = 8'($urandom);
            I_RX = 8'($urandom); I_RY = 8'($urandom);
            I_LX = 8'($urandom); I_LY = 8'($urandom);
            for (int i = 0; i < 9; i++)
                host[i] = 8'($urandom);
            host[0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h01;
            host[1] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h42;
            ab = (host[0] == 8'h01) && (host[1] == 8'h42) && ($urandom_range(0, 5) == 0);
            run_txn(m, ab);
        end

        step(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
